i2c_codec_responder: RTL and testbench

Bench and loopback model of the audio codec's I2C control port: the target side of the codec configuration writes issued by the team's setup controller. Samples SCL/SDA with the system clock, recognises 3-byte writes (device address, register address plus data bit 8, data bits 7:0), ACKs them by pulling SDA low, and updates a 10-entry × 9-bit register file with codec reset defaults. Placed on the FPGA_I2C_SCLK/FPGA_I2C_SDAT net opposite the setup controller, in simulation or as an on-chip loopback.

---
 rtl/i2c_codec_responder.sv | 207 ++++++++++++++++++++
 tb/tb_i2c_codec_responder.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_codec_responder.sv
// I2C target model of the audio codec control port: decodes 3-byte writes to 7'h1A,
// ACKs them and maintains the 10 x 9-bit codec register file.
module i2c_codec_responder (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       scl_i,
   input  logic       sda_i,
   output logic       sda_oe_o,
   output logic       wr_valid_o,
   output logic [6:0] wr_addr_o,
   output logic [8:0] wr_data_o,
   input  logic [3:0] rd_addr_i,
   output logic [8:0] rd_data_o,
   output logic       active_o,
   output logic       busy_o,
   output logic       err_o
);
   localparam logic [6:0] DEV_ADDR = 7'h1A;

   typedef enum logic [3:0] {
      IDLE, ADDR, ACK_A, BYTE1, ACK_1, BYTE2, ACK_2, EXTRA, NACK_WAIT
   } state_t;

   function automatic logic [8:0] reg_default(input logic [3:0] idx);
      case (idx)
         4'd0:    reg_default = 9'h097;
         4'd1:    reg_default = 9'h097;
         4'd2:    reg_default = 9'h079;
         4'd3:    reg_default = 9'h079;
         4'd4:    reg_default = 9'h00A;
         4'd5:    reg_default = 9'h008;
         4'd6:    reg_default = 9'h09F;
         4'd7:    reg_default = 9'h00A;
         default: reg_default = 9'h000;
      endcase
   endfunction

   // [0],[1] form the synchroniser, [2] is the history flop used for edge detection
   logic [2:0] scl_pipe_r;
   logic [2:0] sda_pipe_r;
   state_t     state_r, state_n;
   logic [3:0] cnt_r, cnt_n;
   logic [7:0] shift_r, shift_n;
   logic [7:0] byte1_r, byte1_n;
   logic       sda_oe_r, busy_r, err_r, wr_valid_r;
   logic [6:0] wr_addr_r;
   logic [8:0] wr_data_r;
   logic [8:0] regs_r [0:9];
   logic       commit_s, err_s;
   logic [6:0] commit_addr_s;
   logic [8:0] commit_data_s;
   logic       scl_rise_s, scl_fall_s, start_s, stop_s;
   logic [8:0] rd_data_s;

   assign scl_rise_s    = scl_pipe_r[1] & ~scl_pipe_r[2];
   assign scl_fall_s    = ~scl_pipe_r[1] & scl_pipe_r[2];
   assign start_s       = scl_pipe_r[1] & scl_pipe_r[2] & sda_pipe_r[2] & ~sda_pipe_r[1];
   assign stop_s        = scl_pipe_r[1] & scl_pipe_r[2] & ~sda_pipe_r[2] & sda_pipe_r[1];
   assign commit_addr_s = byte1_r[7:1];
   assign commit_data_s = {byte1_r[0], shift_r};

   // Bus synchronisers, reset to the idle-high bus level
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         scl_pipe_r <= 3'b111;
         sda_pipe_r <= 3'b111;
      end else begin
         scl_pipe_r <= {scl_pipe_r[1:0], scl_i};
         sda_pipe_r <= {sda_pipe_r[1:0], sda_i};
      end
   end

   // Next-state logic: START/STOP override all bit-level events
   always_comb begin
      state_n  = state_r;
      cnt_n    = cnt_r;
      shift_n  = shift_r;
      byte1_n  = byte1_r;
      commit_s = 1'b0;
      err_s    = 1'b0;
      if (stop_s) begin
         state_n = IDLE;
         cnt_n   = 4'd0;
      end else if (start_s) begin
         state_n = ADDR;
         cnt_n   = 4'd0;
      end else begin
         case (state_r)
            ADDR, BYTE1, BYTE2, EXTRA: begin
               if (scl_rise_s && (cnt_r < 4'd8)) begin
                  shift_n = {shift_r[6:0], sda_pipe_r[1]};
                  cnt_n   = cnt_r + 4'd1;
               end else if (scl_fall_s && (cnt_r == 4'd8)) begin
                  cnt_n = 4'd0;
                  case (state_r)
                     ADDR: begin
                        if (shift_r == {DEV_ADDR, 1'b0}) begin
                           state_n = ACK_A;
                        end else if (shift_r == {DEV_ADDR, 1'b1}) begin
                           state_n = NACK_WAIT;
                           err_s   = 1'b1;
                        end else begin
                           state_n = NACK_WAIT;
                        end
                     end
                     BYTE1: begin
                        state_n = ACK_1;
                        byte1_n = shift_r;
                     end
                     BYTE2: begin
                        state_n  = ACK_2;
                        commit_s = 1'b1;
                        if ((commit_addr_s > 7'd9) && (commit_addr_s != 7'd15)) begin
                           err_s = 1'b1;
                        end else begin
                           err_s = 1'b0;
                        end
                     end
                     EXTRA: begin
                        // count 9 marks the NACKed ninth clock so its rise is not shifted
                        err_s = 1'b1;
                        cnt_n = 4'd9;
                     end
                     default: state_n = state_r;
                  endcase
               end else if (scl_fall_s && (cnt_r == 4'd9)) begin
                  cnt_n = 4'd0;
               end else begin
                  cnt_n = cnt_r;
               end
            end
            ACK_A: begin
               if (scl_fall_s) state_n = BYTE1;
               else            state_n = state_r;
            end
            ACK_1: begin
               if (scl_fall_s) state_n = BYTE2;
               else            state_n = state_r;
            end
            ACK_2: begin
               if (scl_fall_s) state_n = EXTRA;
               else            state_n = state_r;
            end
            IDLE, NACK_WAIT: state_n = state_r;
            default:         state_n = IDLE;
         endcase
      end
   end

   // FSM state and registered outputs
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_r    <= IDLE;
         cnt_r      <= 4'd0;
         shift_r    <= 8'h00;
         byte1_r    <= 8'h00;
         sda_oe_r   <= 1'b0;
         busy_r     <= 1'b0;
         err_r      <= 1'b0;
         wr_valid_r <= 1'b0;
         wr_addr_r  <= 7'd0;
         wr_data_r  <= 9'd0;
      end else begin
         state_r    <= state_n;
         cnt_r      <= cnt_n;
         shift_r    <= shift_n;
         byte1_r    <= byte1_n;
         sda_oe_r   <= (state_n == ACK_A) || (state_n == ACK_1) || (state_n == ACK_2);
         busy_r     <= (state_n != IDLE);
         err_r      <= err_s;
         wr_valid_r <= commit_s;
         if (commit_s) begin
            wr_addr_r <= commit_addr_s;
            wr_data_r <= commit_data_s;
         end
      end
   end

   // Register file: write commit, or full restore on register 15
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < 10; i++) regs_r[i] <= reg_default(4'(i));
      end else if (commit_s) begin
         if (commit_addr_s <= 7'd9) begin
            regs_r[commit_addr_s[3:0]] <= commit_data_s;
         end else if (commit_addr_s == 7'd15) begin
            for (int i = 0; i < 10; i++) regs_r[i] <= reg_default(4'(i));
         end
      end
   end

   // Combinational register read with out-of-range index returning zero
   always_comb begin
      if (rd_addr_i <= 4'd9) rd_data_s = regs_r[rd_addr_i];
      else                   rd_data_s = 9'h000;
   end

   assign rd_data_o  = rd_data_s;
   assign sda_oe_o   = sda_oe_r;
   assign busy_o     = busy_r;
   assign err_o      = err_r;
   assign wr_valid_o = wr_valid_r;
   assign wr_addr_o  = wr_addr_r;
   assign wr_data_o  = wr_data_r;
   assign active_o   = regs_r[9][0];

endmodule

// File: tb/tb_i2c_codec_responder.sv
// Directed bench for i2c_codec_responder: a bit-banged I2C master, a register-file
// model and a write scoreboard checked whenever wr_valid_o pulses.
module tb_i2c_codec_responder;
   localparam int T = 60;

   logic       clk = 1'b0;
   logic       rst;
   logic       m_scl, m_sda, sda_bus;
   logic       sda_oe, wr_valid, active, busy, err;
   logic [6:0] wr_addr;
   logic [8:0] wr_data, rd_data;
   logic [3:0] rd_addr;

   int checks = 0, errors = 0;
   int wr_cnt = 0, err_cnt = 0, exp_wr = 0, exp_err = 0;
   logic [15:0] exp_q[$];
   logic [8:0]  model [10];
   logic [8:0]  dflt [10] = '{9'h097, 9'h097, 9'h079, 9'h079, 9'h00A,
                              9'h008, 9'h09F, 9'h00A, 9'h000, 9'h000};

   assign sda_bus = m_sda & ~sda_oe;

   i2c_codec_responder dut (
      .clk_i(clk), .rst_i(rst), .scl_i(m_scl), .sda_i(sda_bus),
      .sda_oe_o(sda_oe), .wr_valid_o(wr_valid), .wr_addr_o(wr_addr),
      .wr_data_o(wr_data), .rd_addr_i(rd_addr), .rd_data_o(rd_data),
      .active_o(active), .busy_o(busy), .err_o(err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: pop expected write on every commit pulse
   always @(negedge clk) begin
      logic [15:0] e;
      if (wr_valid) begin
         wr_cnt++;
         check("wr_expected_pending", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("wr_addr", 32'(wr_addr), 32'(e[15:9]));
            check("wr_data", 32'(wr_data), 32'(e[8:0]));
         end
      end
      if (err) err_cnt++;
   end

   task automatic expect_write(input logic [6:0] a, input logic [8:0] d);
      exp_q.push_back({a, d});
      exp_wr++;
      if (a <= 7'd9) model[a[3:0]] = d;
      else if (a == 7'd15) for (int i = 0; i < 10; i++) model[i] = dflt[i];
      else exp_err++;
   endtask

   task automatic restore_model();
      for (int i = 0; i < 10; i++) model[i] = dflt[i];
   endtask

   task automatic check_regs(input string tag);
      for (int i = 0; i < 16; i++) begin
         rd_addr = 4'(i);
         #10;
         check($sformatf("%s_r%0d", tag, i), 32'(rd_data), (i < 10) ? 32'(model[i]) : 32'd0);
      end
   endtask

   task automatic check_counts(input string tag);
      check({tag, "_wr_cnt"}, wr_cnt, exp_wr);
      check({tag, "_err_cnt"}, err_cnt, exp_err);
   endtask

   task automatic i2c_start();
      m_sda = 1'b1; #T;
      m_scl = 1'b1; #T;
      m_sda = 1'b0; #T;
      m_scl = 1'b0; #T;
   endtask

   task automatic i2c_stop();
      m_sda = 1'b0; #T;
      m_scl = 1'b1; #T;
      m_sda = 1'b1; #(2*T);
   endtask

   task automatic i2c_bit(input logic b);
      m_sda = b;    #T;
      m_scl = 1'b1; #(2*T);
      m_scl = 1'b0; #T;
   endtask

   task automatic i2c_byte(input logic [7:0] d, input logic ack, input string tag);
      for (int i = 7; i >= 0; i--) i2c_bit(d[i]);
      m_sda = 1'b1; #T;
      m_scl = 1'b1; #T;
      check({tag, "_ack"}, 32'(sda_oe), 32'(ack));
      #T;
      m_scl = 1'b0; #T;
   endtask

   initial begin
      rst = 1'b1; m_scl = 1'b1; m_sda = 1'b1; rd_addr = 4'd0;
      restore_model();
      #20;
      check("rst_sda_oe", 32'(sda_oe), 32'd0);
      check("rst_wr_valid", 32'(wr_valid), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_wr_addr", 32'(wr_addr), 32'd0);
      check("rst_wr_data", 32'(wr_data), 32'd0);
      check("rst_active", 32'(active), 32'd0);
      rst = 1'b0; #20;
      check_regs("reset");

      // 34,12,01: R9 = 001, digital interface active
      i2c_start();
      i2c_byte(8'h34, 1'b1, "w1_a");
      i2c_byte(8'h12, 1'b1, "w1_b1");
      expect_write(7'd9, 9'h001);
      i2c_byte(8'h01, 1'b1, "w1_b2");
      check("w1_busy", 32'(busy), 32'd1);
      i2c_stop();
      check("w1_idle", 32'(busy), 32'd0);
      check("w1_active", 32'(active), 32'd1);
      check_counts("w1");
      check_regs("w1");

      // foreign address: ignored, busy until STOP
      i2c_start();
      i2c_byte(8'h36, 1'b0, "foreign");
      check("foreign_busy", 32'(busy), 32'd1);
      i2c_bit(1'b0);
      i2c_stop();
      check("foreign_idle", 32'(busy), 32'd0);
      check_counts("foreign");
      check_regs("foreign");

      // read address: NACK plus one error pulse
      i2c_start();
      i2c_byte(8'h35, 1'b0, "read");
      exp_err++;
      check_counts("read");
      i2c_stop();
      check("read_idle", 32'(busy), 32'd0);

      // R7 write, then register 15 restores defaults
      i2c_start();
      i2c_byte(8'h34, 1'b1, "w7_a");
      i2c_byte(8'h0E, 1'b1, "w7_b1");
      expect_write(7'd7, 9'h04A);
      i2c_byte(8'h4A, 1'b1, "w7_b2");
      i2c_stop();
      check_regs("w7");
      i2c_start();
      i2c_byte(8'h34, 1'b1, "r15_a");
      i2c_byte(8'h1E, 1'b1, "r15_b1");
      expect_write(7'd15, 9'h000);
      i2c_byte(8'h00, 1'b1, "r15_b2");
      i2c_stop();
      check("r15_active", 32'(active), 32'd0);
      check_counts("r15");
      check_regs("r15");

      // STOP after 4 bits of byte 2 discards the write
      i2c_start();
      i2c_byte(8'h34, 1'b1, "part_a");
      i2c_byte(8'h08, 1'b1, "part_b1");
      i2c_bit(1'b0); i2c_bit(1'b0); i2c_bit(1'b0); i2c_bit(1'b1);
      i2c_stop();
      check_counts("part");
      check_regs("part");
      i2c_start();
      i2c_byte(8'h34, 1'b1, "w4_a");
      i2c_byte(8'h08, 1'b1, "w4_b1");
      expect_write(7'd4, 9'h01F);
      i2c_byte(8'h1F, 1'b1, "w4_b2");
      i2c_stop();
      check_counts("w4");
      check_regs("w4");

      // out-of-range register 10: pulse plus error, no update
      i2c_start();
      i2c_byte(8'h34, 1'b1, "bad_a");
      i2c_byte(8'h14, 1'b1, "bad_b1");
      expect_write(7'd10, 9'h000);
      i2c_byte(8'h00, 1'b1, "bad_b2");
      i2c_stop();
      check_counts("bad");
      check_regs("bad");

      // extra fourth byte is NACKed with one error pulse
      i2c_start();
      i2c_byte(8'h34, 1'b1, "ext_a");
      i2c_byte(8'h12, 1'b1, "ext_b1");
      expect_write(7'd9, 9'h001);
      i2c_byte(8'h01, 1'b1, "ext_b2");
      i2c_byte(8'hFF, 1'b0, "ext_b3");
      exp_err++;
      i2c_stop();
      check_counts("ext");
      check("ext_active", 32'(active), 32'd1);
      check_regs("ext");

      // reset while the ACK is driven: SDA released without a clock edge
      i2c_start();
      for (int i = 7; i >= 0; i--) i2c_bit(((8'h34 >> i) & 8'h01) != 8'h00);
      m_sda = 1'b1; #T;
      m_scl = 1'b1; #T;
      check("rst_mid_ack_before", 32'(sda_oe), 32'd1);
      rst = 1'b1; #2;
      check("rst_mid_sda_oe", 32'(sda_oe), 32'd0);
      check("rst_mid_busy", 32'(busy), 32'd0);
      #8;
      restore_model();
      rst = 1'b0; #(2*T);
      check("rst_mid_active", 32'(active), 32'd0);
      check_regs("rst_mid");

      // bus recovers at the next START
      i2c_start();
      i2c_byte(8'h34, 1'b1, "rec_a");
      i2c_byte(8'h12, 1'b1, "rec_b1");
      expect_write(7'd9, 9'h001);
      i2c_byte(8'h01, 1'b1, "rec_b2");
      i2c_stop();
      check_counts("rec");
      check_regs("rec");
      check("final_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
